// File: rtl/instruction_memory_responder.sv
// instruction_memory_responder
// Responder end of the instruction fetch handshake. It accepts a word-address
// request, reads the internal instruction array after LATENCY cycles, and
// returns the word with a single-cycle ack. It flags 'last' on the highest
// loaded word. A separate write port loads the program image and tracks the
// program end.
// Optional feature macro: IMEM_ALIGN_CHECK_EN. When it is defined, misaligned
// requests fault with err=1 and misaligned writes are dropped. When it is not
// defined, the low two address bits are ignored and err is always 0.

module instruction_memory_responder #(
    parameter int IWIDTH       = 32,
    parameter int AWIDTH_INSTR = 32,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 1
) (
    input  logic                    im_clk,
    input  logic                    im_rst,
    input  logic                    im_i_syn,
    input  logic [AWIDTH_INSTR-1:0] im_i_addr,
    input  logic                    im_i_flush,
    input  logic                    im_i_we,
    input  logic [AWIDTH_INSTR-1:0] im_i_waddr,
    input  logic [IWIDTH-1:0]       im_i_wdata,
    output logic [IWIDTH-1:0]       im_o_instr,
    output logic                    im_o_ack,
    output logic                    im_o_last,
    output logic                    im_o_err,
    output logic                    im_o_busy
);

    localparam int                IDXW      = $clog2(DEPTH);
    localparam logic [IWIDTH-1:0] NOP_WORD  = IWIDTH'(32'h0000_0013);
    localparam logic [3:0]        WAIT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [IWIDTH-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              oor_q, oor_d;
    logic              mis_q, mis_d;
    logic [IWIDTH-1:0] instr_q, instr_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [IDXW-1:0]   endIdx_q, endIdx_d;

    logic              enterResp;

    logic [IDXW-1:0]   reqIdx;
    logic              reqOor;
    logic              reqMis;

    logic [IDXW-1:0]   rdIdx;
    logic              rdOor;
    logic              rdMis;
    logic              rdBad;
    logic              rdErr;

    logic [IDXW-1:0]   wrIdx;
    logic              wrOor;
    logic              wrMis;
    logic              wrOk;

    assign reqIdx = im_i_addr[IDXW+1:2];
    assign reqOor = (im_i_addr >> (IDXW + 2)) != '0;
    assign reqMis = im_i_addr[1:0] != 2'b00;

    assign wrIdx  = im_i_waddr[IDXW+1:2];
    assign wrOor  = (im_i_waddr >> (IDXW + 2)) != '0;
    assign wrMis  = im_i_waddr[1:0] != 2'b00;

    assign rdIdx  = (state_q == S_IDLE) ? reqIdx : idx_q;
    assign rdOor  = (state_q == S_IDLE) ? reqOor : oor_q;
    assign rdMis  = (state_q == S_IDLE) ? reqMis : mis_q;

`ifdef IMEM_ALIGN_CHECK_EN
    assign rdBad  = rdOor || rdMis;
    assign rdErr  = rdBad;
    assign wrOk   = im_i_we && !wrOor && !wrMis;
`else
    logic unusedAlignFlags;
    assign unusedAlignFlags = rdMis ^ wrMis;
    assign rdBad  = rdOor;
    assign rdErr  = 1'b0;
    assign wrOk   = im_i_we && !wrOor;
`endif

    // Request sequencing: accept in IDLE, count down in WAIT, ack for one cycle in RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        oor_d     = oor_q;
        mis_d     = mis_q;
        enterResp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (im_i_syn && !im_i_flush) begin
                    idx_d = reqIdx;
                    oor_d = reqOor;
                    mis_d = reqMis;
                    if (LATENCY == 1) begin
                        state_d   = S_RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (im_i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d   = S_RESP;
                    enterResp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response word and flags are captured only on the edge that enters RESP.
    always_comb begin
        instr_d = instr_q;
        last_d  = last_q;
        err_d   = err_q;
        if (enterResp) begin
            if (rdBad) begin
                instr_d = NOP_WORD;
                last_d  = 1'b1;
            end else begin
                instr_d = mem[rdIdx];
                last_d  = (rdIdx == endIdx_q);
            end
            err_d = rdErr;
        end
    end

    // Program end follows the highest index that has been loaded.
    always_comb begin
        endIdx_d = endIdx_q;
        if (wrOk && (wrIdx > endIdx_q)) begin
            endIdx_d = wrIdx;
        end
    end

    // State, request latch, response registers and end index, all cleared by reset.
    always_ff @(posedge im_clk) begin
        if (im_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            mis_q    <= 1'b0;
            instr_q  <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            endIdx_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oor_q    <= oor_d;
            mis_q    <= mis_d;
            instr_q  <= instr_d;
            last_q   <= last_d;
            err_q    <= err_d;
            endIdx_q <= endIdx_d;
        end
    end

    // Program-load port; the array keeps its contents across reset.
    always_ff @(posedge im_clk) begin
        if (wrOk) begin
            mem[wrIdx] <= im_i_wdata;
        end
    end

    assign im_o_instr = instr_q;
    assign im_o_last  = last_q;
    assign im_o_err   = err_q;
    assign im_o_ack   = (state_q == S_RESP);
    assign im_o_busy  = (state_q != S_IDLE);

endmodule
